// File: rtl/ahb2apb_mslv_pkg.sv
// Shared definitions for the AHB-to-APB multi-slave bridge:
// FSM state encoding, AHB HTRANS/HRESP codes and small helpers.
package ahb2apb_mslv_pkg;

    localparam int ADDR_W = 40;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    // True when the decoded slave index maps onto an implemented slave.
    function automatic logic idx_valid(input logic [IDX_W-1:0] idx, input int num_slv);
        return int'(idx) < num_slv;
    endfunction

endpackage

// File: rtl/apb_rdata_mux.sv
// Selects the read data, ready and error lines of the addressed APB slave.
// An index outside the implemented range returns all zeros.
module apb_rdata_mux
    import ahb2apb_mslv_pkg::*;
#(
    parameter int NUM_SLV = 8
) (
    input  logic [IDX_W-1:0]          idx,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr,
    output logic [DATA_W-1:0]         sel_rdata,
    output logic                      sel_ready,
    output logic                      sel_slverr
);

    // Pick slice idx out of the flattened slave response buses.
    always_comb begin
        sel_rdata  = '0;
        sel_ready  = 1'b0;
        sel_slverr = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_rdata  = prdata[DATA_W*i +: DATA_W];
                sel_ready  = pready[i];
                sel_slverr = pslverr[i];
            end
        end
    end

endmodule

// File: rtl/ahb2apb_mslv.sv
// AHB-Lite slave to multi-slave APB bridge.
// The slave index is haddr[SEL_LSB+3:SEL_LSB]; indices beyond NUM_SLV get a
// two-cycle AHB ERROR response without touching the APB bus.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that
// has waited TIMEOUT_CYC cycles for pready with an AHB ERROR response.
module ahb2apb_mslv
    import ahb2apb_mslv_pkg::*;
#(
    parameter int NUM_SLV     = 8,
    parameter int SEL_LSB     = 12,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                      hclk,
    input  logic                      hrst,
    // AHB slave side
    input  logic                      hsel,
    input  logic [ADDR_W-1:0]         haddr,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [DATA_W-1:0]         hwdata,
    input  logic                      hready,
    output logic                      hreadyout,
    output logic [1:0]                hresp,
    output logic [DATA_W-1:0]         hrdata,
    // APB master side
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    output logic                      penable,
    output logic [NUM_SLV-1:0]        psel,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    state_e            state;
    state_e            state_nxt;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  haddr_idx;
    logic              accept;
    logic              in_apb;
    logic [DATA_W-1:0] sel_rdata;
    logic              sel_ready;
    logic              sel_slverr;
    logic              tmo_hit;

    // hsize is ignored (all APB accesses are 32-bit) and only htrans[1]
    // distinguishes NONSEQ/SEQ from IDLE/BUSY.
    logic unused_bits;
    assign unused_bits = ^{hsize, htrans[0]};

    assign haddr_idx = haddr[SEL_LSB +: IDX_W];

    // A new transfer can only start while the bridge is presenting a ready
    // data phase (IDLE or DONE); in ERR2 the master cancels the next transfer.
    assign accept = hsel && hready && htrans[1] &&
                    ((state == ST_IDLE) || (state == ST_DONE));

    assign in_apb = (state == ST_SETUP) || (state == ST_ACCESS);

    apb_rdata_mux #(
        .NUM_SLV (NUM_SLV)
    ) u_rdata_mux (
        .idx        (idx_q),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .sel_rdata  (sel_rdata),
        .sel_ready  (sel_ready),
        .sel_slverr (sel_slverr)
    );

`ifdef APB_TIMEOUT_EN
    logic [CNT_W-1:0] acc_cnt;

    // Count ACCESS cycles; the counter sits at zero outside ACCESS so each
    // new ACCESS phase starts from zero.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            acc_cnt <= '0;
        end else if (state == ST_ACCESS) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end else begin
            acc_cnt <= '0;
        end
    end

    assign tmo_hit = (state == ST_ACCESS) && (acc_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic [CNT_W-1:0] unused_tmo;
    assign unused_tmo = CNT_W'(TIMEOUT_CYC);
    assign tmo_hit    = 1'b0;
`endif

    // Next-state decode; a ready slave in the final timeout cycle still
    // completes normally because pready is tested first.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_nxt = idx_valid(haddr_idx, NUM_SLV) ? ST_SETUP : ST_ERR1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_ready) begin
                    state_nxt = sel_slverr ? ST_ERR1 : ST_DONE;
                end else if (tmo_hit) begin
                    state_nxt = ST_ERR1;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the address phase; paddr/pwrite then stay put through
    // SETUP and ACCESS because nothing is accepted until DONE.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            idx_q  <= '0;
            paddr  <= '0;
            pwrite <= 1'b0;
        end else if (accept) begin
            idx_q  <= haddr_idx;
            paddr  <= haddr;
            pwrite <= hwrite;
        end
    end

    // Load read data when the slave completes a read, even with pslverr
    // set; writes, decode errors and timeouts leave hrdata untouched.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            hrdata <= '0;
        end else if ((state == ST_ACCESS) && sel_ready && !pwrite) begin
            hrdata <= sel_rdata;
        end
    end

    // One-hot slave select, decoded from the registered state so that an
    // asynchronous reset removes it immediately.
    always_comb begin
        psel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            psel[i] = in_apb && (idx_q == IDX_W'(i));
        end
    end

    assign penable   = (state == ST_ACCESS);
    assign hreadyout = !(in_apb || (state == ST_ERR1));
    assign hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    // hreadyout is low through SETUP and ACCESS, so the master holds hwdata.
    assign pwdata = hwdata;

endmodule

// File: tb/tb_ahb2apb_mslv.sv
// Directed self-checking bench for ahb2apb_mslv (NUM_SLV=8, SEL_LSB=12).
// Built with APB_TIMEOUT_EN it uses TIMEOUT_CYC=4 and checks the timeout;
// otherwise it checks that ACCESS waits 1000 cycles without giving up.
module tb_ahb2apb_mslv;

    localparam int NS = 8;
`ifdef APB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 256;
`endif

    logic           hclk = 1'b0;
    logic           hrst;
    logic           hsel;
    logic [39:0]    haddr;
    logic [1:0]     htrans;
    logic           hwrite;
    logic [2:0]     hsize;
    logic [31:0]    hwdata;
    logic           hready;
    logic           hreadyout;
    logic [1:0]     hresp;
    logic [31:0]    hrdata;
    logic [39:0]    paddr;
    logic           pwrite;
    logic [31:0]    pwdata;
    logic           penable;
    logic [NS-1:0]  psel;
    logic [NS*32-1:0] prdata;
    logic [NS-1:0]  pready;
    logic [NS-1:0]  pslverr;

    int checks = 0;
    int errors = 0;

    // Results collected by xfer
    int            r_low;
    int            r_en;
    logic [NS-1:0] r_psel_or;
    logic [NS-1:0] r_first_psel;
    logic [39:0]   r_first_paddr;
    logic          r_first_pwrite;
    logic [31:0]   r_pwdata;
    logic          r_err_low;
    logic [1:0]    r_resp;
    logic          r_tmo;

    always #5 hclk = ~hclk;

    assign hready = hreadyout;

    ahb2apb_mslv #(
        .NUM_SLV     (NS),
        .SEL_LSB     (12),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .hclk      (hclk),
        .hrst      (hrst),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .penable   (penable),
        .psel      (psel),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one transfer starting at the current negedge (DUT in IDLE/DONE),
    // act as the APB slave (pready low for 'waits' ACCESS cycles) and return
    // at the negedge where hreadyout is high, or after 'bound' stalled cycles.
    task automatic xfer(input logic [39:0] a, input logic wr, input logic [31:0] wd,
                        input int waits, input logic [NS-1:0] err, input int bound);
        bit done;
        hsel    = 1'b1;
        htrans  = 2'b10;
        haddr   = a;
        hwrite  = wr;
        pready  = '0;
        pslverr = err;
        r_low = 0; r_en = 0; r_psel_or = '0; r_err_low = 1'b0; r_tmo = 1'b0;
        r_first_psel = '0; r_first_paddr = '0; r_first_pwrite = 1'b0;
        r_pwdata = '0; r_resp = 2'b00;
        @(negedge hclk);
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = '0;
        hwrite = 1'b0;
        hwdata = wd;
        done = 1'b0;
        while (!done) begin
            if (hreadyout) begin
                r_resp = hresp;
                done = 1'b1;
            end else if (r_low == bound) begin
                r_tmo = 1'b1;
                done = 1'b1;
            end else begin
                if (r_low == 0) begin
                    r_first_psel   = psel;
                    r_first_paddr  = paddr;
                    r_first_pwrite = pwrite;
                end
                r_low++;
                r_psel_or = r_psel_or | psel;
                if (hresp == 2'b01) r_err_low = 1'b1;
                if (penable) begin
                    r_en++;
                    r_pwdata = pwdata;
                end
                pready = (penable && (r_en > waits)) ? '1 : '0;
                @(negedge hclk);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        hrst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'b010; hwdata = '0; pready = '0; pslverr = '0;
        for (int i = 0; i < NS; i++) prdata[32*i +: 32] = 32'hA5A5_0000 + 32'(i) - 32'd1;

        // Reset state
        @(negedge hclk);
        @(negedge hclk);
        check("rst_psel",      64'(psel),      64'h0);
        check("rst_penable",   64'(penable),   64'h0);
        check("rst_paddr",     64'(paddr),     64'h0);
        check("rst_pwrite",    64'(pwrite),    64'h0);
        check("rst_hrdata",    64'(hrdata),    64'h0);
        check("rst_hreadyout", 64'(hreadyout), 64'h1);
        check("rst_hresp",     64'(hresp),     64'h0);
        hrst = 1'b0;
        @(negedge hclk);

        // BUSY transfer is ignored: zero-wait OKAY, no APB activity
        hsel = 1'b1; htrans = 2'b01; haddr = 40'h2004;
        @(negedge hclk);
        check("busy_hreadyout", 64'(hreadyout), 64'h1);
        check("busy_psel",      64'(psel),      64'h0);
        check("busy_hresp",     64'(hresp),     64'h0);
        hsel = 1'b0; htrans = 2'b00;

        // Read slave 2, zero wait
        xfer(40'h0000_2004, 1'b0, 32'h0, 0, '0, 20);
        check("rd2_psel",   64'(r_first_psel),   64'h04);
        check("rd2_paddr",  64'(r_first_paddr),  64'h2004);
        check("rd2_pwrite", 64'(r_first_pwrite), 64'h0);
        check("rd2_low",    64'(r_low),          64'd2);
        check("rd2_resp",   64'(r_resp),         64'h0);
        check("rd2_hrdata", 64'(hrdata),         64'hA5A5_0001);
        check("rd2_done_psel", 64'(psel),        64'h0);

        // Write slave 5 with three wait states
        xfer(40'h0000_5010, 1'b1, 32'h1234_5678, 3, '0, 20);
        check("wr5_psel",   64'(r_first_psel),   64'h20);
        check("wr5_pwrite", 64'(r_first_pwrite), 64'h1);
        check("wr5_pwdata", 64'(r_pwdata),       64'h1234_5678);
        check("wr5_en",     64'(r_en),           64'd4);
        check("wr5_low",    64'(r_low),          64'd5);
        check("wr5_resp",   64'(r_resp),         64'h0);
        check("wr5_hrdata", 64'(hrdata),         64'hA5A5_0001);

        // Unimplemented slave 9: ERROR without APB access
        xfer(40'h0000_9000, 1'b0, 32'h0, 0, '0, 20);
        check("bad_psel",    64'(r_psel_or), 64'h0);
        check("bad_low",     64'(r_low),     64'd1);
        check("bad_errlow",  64'(r_err_low), 64'h1);
        check("bad_resp",    64'(r_resp),    64'h1);
        check("bad_hrdata",  64'(hrdata),    64'hA5A5_0001);

        // Transfer offered during ERR2 is not accepted
        hsel = 1'b1; htrans = 2'b10; haddr = 40'h0000_1000;
        @(negedge hclk);
        check("err2_noacc_psel", 64'(psel),      64'h0);
        check("err2_noacc_rdy",  64'(hreadyout), 64'h1);
        hsel = 1'b0; htrans = 2'b00; haddr = '0;
        @(negedge hclk);

        // Slave 1 read with pslverr: ERR1/ERR2, data still loaded
        xfer(40'h0000_1008, 1'b0, 32'h0, 0, 8'b0000_0010, 20);
        check("slverr_psel",   64'(r_first_psel), 64'h02);
        check("slverr_low",    64'(r_low),        64'd3);
        check("slverr_errlow", 64'(r_err_low),    64'h1);
        check("slverr_resp",   64'(r_resp),       64'h1);
        check("slverr_hrdata", 64'(hrdata),       64'hA5A5_0000);
        pslverr = '0;
        @(negedge hclk);

        // Back-to-back reads: slave 0 then slave 3 issued in DONE
        xfer(40'h0000_0010, 1'b0, 32'h0, 0, '0, 20);
        check("b2b0_hrdata", 64'(hrdata), 64'hA5A4_FFFF);
        xfer(40'h0000_3000, 1'b0, 32'h0, 0, '0, 20);
        check("b2b3_psel",   64'(r_first_psel), 64'h08);
        check("b2b3_low",    64'(r_low),        64'd2);
        check("b2b3_hrdata", 64'(hrdata),       64'hA5A5_0002);

        // Reset pulse in the middle of ACCESS
        xfer(40'h0000_4000, 1'b0, 32'h0, 100, '0, 3);
        check("rstmid_tmo",     64'(r_tmo),   64'h1);
        check("rstmid_pen_pre", 64'(penable), 64'h1);
        hrst = 1'b1;
        #1;
        check("rstmid_psel",    64'(psel),      64'h0);
        check("rstmid_penable", 64'(penable),   64'h0);
        check("rstmid_rdy",     64'(hreadyout), 64'h1);
        @(negedge hclk);
        hrst = 1'b0;
        @(negedge hclk);

`ifdef APB_TIMEOUT_EN
        // Slave 6 never ready: four ACCESS cycles, then ERROR
        xfer(40'h0000_6000, 1'b0, 32'h0, 100000, '0, 50);
        check("tmo_tmo",    64'(r_tmo),     64'h0);
        check("tmo_en",     64'(r_en),      64'd4);
        check("tmo_low",    64'(r_low),     64'd6);
        check("tmo_psel",   64'(r_psel_or), 64'h40);
        check("tmo_errlow", 64'(r_err_low), 64'h1);
        check("tmo_resp",   64'(r_resp),    64'h1);
`else
        // Slave 6 never ready: ACCESS persists for 1000 cycles
        xfer(40'h0000_6000, 1'b0, 32'h0, 100000, '0, 1001);
        check("wait_tmo",  64'(r_tmo),     64'h1);
        check("wait_en",   64'(r_en),      64'd1000);
        check("wait_pen",  64'(penable),   64'h1);
        check("wait_psel", 64'(psel),      64'h40);
        check("wait_err",  64'(r_err_low), 64'h0);
        hrst = 1'b1;
        @(negedge hclk);
        hrst = 1'b0;
`endif
        @(negedge hclk);
        check("end_idle_rdy", 64'(hreadyout), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb2apb_mslv.md
AHB2APB_MSLV -- requirements
Module: ahb2apb_mslv

Interface
REQ-001 SHALL: parameter NUM_SLV, default 8, number of APB slaves (legal 1..16).
REQ-002 SHALL: parameter SEL_LSB, default 12, lowest haddr bit of the 4-bit slave-index field haddr[SEL_LSB+3:SEL_LSB].
REQ-003 SHALL: parameter TIMEOUT_CYC, default 256, maximum ACCESS cycles before timeout (legal 2..65535).
REQ-004 SHALL: port hclk, input, 1, sole clock, rising edge.
REQ-005 SHALL: port hrst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL: AHB inputs hsel 1, haddr 40, htrans 2, hwrite 1, hsize 3, hwdata 32, hready 1 (bus-level hready).
REQ-007 SHALL: AHB outputs hreadyout 1, hresp 2 (00 OKAY, 01 ERROR), hrdata 32.
REQ-008 SHALL: APB outputs paddr 40, pwrite 1, pwdata 32, penable 1, psel NUM_SLV (one-hot).
REQ-009 SHALL: APB inputs prdata NUM_SLV*32 (slave i at [32i+31:32i]), pready NUM_SLV, pslverr NUM_SLV.

Function
REQ-010 SHALL: FSM states IDLE, SETUP, ACCESS, DONE, ERR1, ERR2.
REQ-011 SHALL: accept a transfer when hsel & hready & htrans[1] in IDLE or DONE; latch haddr, hwrite and index idx.
REQ-012 SHALL: idx < NUM_SLV -> SETUP next cycle; idx >= NUM_SLV -> ERR1, with no psel asserted.
REQ-013 SHALL: SETUP: psel[idx]=1, penable=0, hreadyout=0; always -> ACCESS.
REQ-014 SHALL: ACCESS: psel[idx]=1, penable=1, hreadyout=0; stay while pready[idx]=0.
REQ-015 SHALL: ACCESS with pready[idx]=1 and pslverr[idx]=0 -> DONE; on read, load hrdata from prdata slice idx.
REQ-016 SHALL: ACCESS with pready[idx]=1 and pslverr[idx]=1 -> ERR1; on read, hrdata is still loaded.
REQ-017 SHALL: DONE: hreadyout=1, hresp=OKAY, psel=0; new accepted transfer -> SETUP or ERR1, else -> IDLE.
REQ-018 SHALL: ERR1: hreadyout=0, hresp=ERROR; ERR2: hreadyout=1, hresp=ERROR; ERR1 always -> ERR2.
REQ-019 SHALL: ERR2 -> IDLE; a transfer presented during ERR2 is not accepted (AHB master cancels it).
REQ-020 SHALL: IDLE: hreadyout=1, hresp=OKAY; htrans IDLE/BUSY or hsel=0 -> OKAY with zero wait.
REQ-021 SHALL: paddr and pwrite are registered from the latch and stable from SETUP through ACCESS.
REQ-022 SHALL: pwdata = hwdata, passed through; it is valid because hreadyout=0 holds hwdata throughout SETUP and ACCESS.
REQ-023 SHALL: zero-wait APB latency is address phase T0, SETUP T1, ACCESS T2, hreadyout=1 in T3.
REQ-024 SHALL: hrdata holds its last loaded value; writes and errors (except REQ-016) leave it unchanged.
REQ-025 SHALL: hsize is ignored; all APB accesses are 32-bit.

Reset
REQ-026 SHALL: on hrst=1, asynchronously enter IDLE, with psel=0, penable=0, paddr=0, pwrite=0, hrdata=0, hreadyout=1, hresp=OKAY, timeout count=0.
REQ-027 SHALL: reset asserted mid-ACCESS drops psel/penable immediately; no response is issued for the aborted transfer.

Configuration
REQ-028 SHALL: macro APB_TIMEOUT_EN defined -> an ACCESS counter starts at 0 on ACCESS entry and increments each ACCESS cycle.
REQ-029 SHALL: with APB_TIMEOUT_EN, a count reaching TIMEOUT_CYC-1 with pready[idx]=0 -> ERR1, psel and penable deasserted next cycle.
REQ-030 SHALL: with APB_TIMEOUT_EN, pready[idx]=1 in that same cycle wins; it completes per REQ-015/016.
REQ-031 SHALL: APB_TIMEOUT_EN undefined -> no counter logic; ACCESS waits indefinitely.

Structure
REQ-032 SHALL: package ahb2apb_mslv_pkg holds the FSM state enum, HTRANS codes (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11) and HRESP codes.
REQ-033 SHALL: one sub-module apb_rdata_mux, parametrised by NUM_SLV, selects the prdata/pready/pslverr slice by idx.

Verification
REQ-034 SHALL: read NONSEQ haddr=0x0000_2004, slave 2 pready=1, prdata=0xA5A5_0001 -> psel=0x04, paddr=0x2004, hreadyout low 2 cycles, hrdata=0xA5A5_0001, OKAY.
REQ-035 SHALL: write haddr=0x0000_5010, hwdata=0x1234_5678, slave 5 pready low 3 ACCESS cycles -> pwdata=0x1234_5678, pwrite=1, penable high 4 cycles, OKAY.
REQ-036 SHALL: haddr=0x0000_9000 with NUM_SLV=8 -> no psel, ERROR two-cycle response (hreadyout 0 then 1).
REQ-037 SHALL: slave 1 pslverr=1 with pready=1 -> ERR1/ERR2 sequence, hresp=01 in both cycles.
REQ-038 SHALL: with APB_TIMEOUT_EN and TIMEOUT_CYC=4, pready held 0 -> exactly 4 ACCESS cycles, then ERROR; without the macro, ACCESS persists 1000 cycles.
REQ-039 SHALL: back-to-back reads to slaves 0 and 3 issued in DONE -> second SETUP directly follows DONE, no IDLE cycle; hrst pulse mid-ACCESS -> psel=0 in the same cycle.
